// File: rtl/conv5x5_pkg.sv
// Shared constants for the 5x5 convolution window datapath: kernel geometry,
// sequencer state encoding and the RAM-to-operand delay.
package conv5x5_pkg;

  localparam int K           = 5;
  localparam int TAPS        = K * K;
  localparam int CNT_W       = $clog2(K);
  // Synchronous RAMs return data one cycle after the strobe.
  localparam int OPERAND_DLY = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int unsigned tap_index(input logic [CNT_W-1:0] row,
                                            input logic [CNT_W-1:0] col);
    return row * K + col;
  endfunction

endpackage

// File: rtl/pe_window_sequencer_tap_counter.sv
// Row-major row/col scan over the KxK window; wraps to (0,0) after the last tap.
module tap_counter
  import conv5x5_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_row,
  output logic [CNT_W-1:0] o_col,
  output logic             o_last_tap
);

  logic [CNT_W-1:0] row_reg;
  logic [CNT_W-1:0] col_reg;
  logic             col_last;
  logic             row_last;

  assign col_last = (col_reg == CNT_W'(K - 1));
  assign row_last = (row_reg == CNT_W'(K - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (i_en) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_last ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  assign o_row      = row_reg;
  assign o_col      = col_reg;
  assign o_last_tap = (tap_index(row_reg, col_reg) == TAPS - 1);

endmodule

// File: rtl/pe_window_sequencer.sv
// Walks one PE through a KxK window: issues RAM reads, steers operands and the
// fed-back psum into the PE, and captures the final window sum.
module pe_window_sequencer
  import conv5x5_pkg::*;
#(
  parameter int I_X    = 8,
  parameter int I_W    = 8,
  parameter int O_PSUM = 16,
  parameter int IMG_W  = 32,
  parameter int FM_AW  = 10,
  parameter int W_AW   = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [FM_AW-1:0]  i_base_addr,
  input  logic [O_PSUM-1:0] i_bias,
  output logic              o_busy,
  output logic              o_done,
  output logic [O_PSUM-1:0] o_result,
  output logic              o_fm_rd_en,
  output logic [FM_AW-1:0]  o_fm_addr,
  input  logic [I_X-1:0]    i_fm_rdata,
  output logic              o_w_rd_en,
  output logic [W_AW-1:0]   o_w_addr,
  input  logic [I_W-1:0]    i_w_rdata,
  output logic [I_X-1:0]    o_pe_x,
  output logic [I_W-1:0]    o_pe_w,
  output logic [O_PSUM-1:0] o_pe_psum,
  input  logic [O_PSUM-1:0] i_pe_psum
);

  logic [1:0]             state_reg, state_next;
  logic                   drain_cnt_reg;
  logic [FM_AW-1:0]       base_reg;
  logic [O_PSUM-1:0]      bias_reg;
  logic [O_PSUM-1:0]      result_reg;
  logic [OPERAND_DLY-1:0] valid_sr_reg;
  logic [OPERAND_DLY-1:0] first_sr_reg;

  logic             start_ok;
  logic             rd_en;
  logic             first_tap;
  logic             op_valid;
  logic             op_first;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] col;
  logic             last_tap;

  // A new window may start from IDLE or directly out of DONE.
  assign start_ok  = i_start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign rd_en     = (state_reg == ST_ISSUE);
  assign first_tap = rd_en && (row == '0) && (col == '0);
  assign op_valid  = valid_sr_reg[OPERAND_DLY-1];
  assign op_first  = first_sr_reg[OPERAND_DLY-1];

  tap_counter u_tap_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (start_ok),
    .i_en       (rd_en),
    .o_row      (row),
    .o_col      (col),
    .o_last_tap (last_tap)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_ok) state_next = ST_ISSUE;
      ST_ISSUE: if (last_tap) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt_reg) state_next = ST_DONE;
      ST_DONE:  state_next = start_ok ? ST_ISSUE : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= 1'b0;
      base_reg      <= '0;
      bias_reg      <= '0;
      result_reg    <= '0;
      valid_sr_reg  <= '0;
      first_sr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= (state_reg == ST_DRAIN) ? ~drain_cnt_reg : 1'b0;
      valid_sr_reg  <= OPERAND_DLY'({valid_sr_reg, rd_en});
      first_sr_reg  <= OPERAND_DLY'({first_sr_reg, first_tap});
      if (start_ok) begin
        base_reg <= i_base_addr;
        bias_reg <= i_bias;
      end
      // Second DRAIN cycle: the PE is presenting the sum of the last tap.
      if ((state_reg == ST_DRAIN) && drain_cnt_reg)
        result_reg <= i_pe_psum;
    end
  end

  assign o_busy     = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
  assign o_done     = (state_reg == ST_DONE);
  assign o_result   = result_reg;
  assign o_fm_rd_en = rd_en;
  assign o_w_rd_en  = rd_en;
  assign o_fm_addr  = rd_en ? (base_reg + FM_AW'(row) * FM_AW'(IMG_W) + FM_AW'(col)) : '0;
  assign o_w_addr   = rd_en ? W_AW'(tap_index(row, col)) : '0;
  assign o_pe_x     = op_valid ? i_fm_rdata : '0;
  assign o_pe_w     = op_valid ? i_w_rdata : '0;
  assign o_pe_psum  = !op_valid ? '0 : (op_first ? bias_reg : i_pe_psum);

endmodule

// File: tb/tb_pe_window_sequencer.sv
// Directed bench: behavioural RAMs and PE around the sequencer, table-driven windows
// plus hand-written restart / reset / back-to-back sequences.
module tb_pe_window_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [15:0] bias;
  logic        busy, done;
  logic [15:0] result;
  logic        fm_rd_en, w_rd_en;
  logic [9:0]  fm_addr;
  logic [4:0]  w_addr;
  logic [7:0]  fm_rdata, w_rdata;
  logic [7:0]  pe_x, pe_w;
  logic [15:0] pe_psum_in, pe_psum_out;

  logic [7:0] fm_mem [1024];
  logic [7:0] w_mem  [32];

  int tests_run = 0;
  int tests_failed = 0;

  pe_window_sequencer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_bias      (bias),
    .o_busy      (busy),
    .o_done      (done),
    .o_result    (result),
    .o_fm_rd_en  (fm_rd_en),
    .o_fm_addr   (fm_addr),
    .i_fm_rdata  (fm_rdata),
    .o_w_rd_en   (w_rd_en),
    .o_w_addr    (w_addr),
    .i_w_rdata   (w_rdata),
    .o_pe_x      (pe_x),
    .o_pe_w      (pe_w),
    .o_pe_psum   (pe_psum_in),
    .i_pe_psum   (pe_psum_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAMs and a 1-cycle registered multiply-accumulate PE.
  always @(posedge clk) begin
    if (fm_rd_en) fm_rdata <= fm_mem[fm_addr];
    if (w_rd_en)  w_rdata  <= w_mem[w_addr];
    if (rst) pe_psum_out <= 16'd0;
    else     pe_psum_out <= pe_psum_in + ({{8{pe_x[7]}}, pe_x} * {{8{pe_w[7]}}, pe_w});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  fm;
    logic [7:0]  w;
    logic [15:0] bias;
    logic [9:0]  base;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  // restart_cyc: cycle on which a second i_start (with other base/bias) is driven.
  // rst_cyc: cycle on which i_rst is driven. chain: start again on the o_done cycle.
  task automatic run_window(input int id, input logic [7:0] fmv, input logic [7:0] wv,
                            input logic [15:0] bv, input logic [9:0] bsv,
                            input logic [15:0] exp, input int restart_cyc,
                            input int rst_cyc, input bit chain,
                            input logic [15:0] bias2, input logic [15:0] exp2);
    int done_cyc, done2_cyc, busy_n, busy_first, busy_last, rd_n, p, k;
    bit live;
    logic [15:0] res1, res2, exp_psum;
    logic [9:0]  exp_addr;
    for (int i = 0; i < 1024; i++) fm_mem[i] = fmv;
    for (int i = 0; i < 32; i++)   w_mem[i]  = wv;
    p = int'($signed(fmv)) * int'($signed(wv));
    @(negedge clk);
    base_addr = bsv; bias = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cyc = -1; done2_cyc = -1; busy_n = 0; busy_first = -1; busy_last = -1; rd_n = 0;
    res1 = 16'd0; res2 = 16'd0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      live = (done_cyc < 0) && (rst_cyc < 0 || cyc <= rst_cyc);
      if (live && busy) begin
        busy_n++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (live && fm_rd_en) begin
        exp_addr = 10'(int'(bsv) + (rd_n / 5) * 32 + (rd_n % 5));
        chk("fm_addr", 32'(fm_addr), 32'(exp_addr));
        chk("w_addr", 32'(w_addr), 32'(rd_n));
        chk("w_rd_en", 32'(w_rd_en), 32'd1);
        rd_n++;
      end
      if (live && cyc >= 2 && cyc <= 26) begin
        k = cyc - 2;
        exp_psum = 16'(int'($signed(bv)) + k * p);
        chk("pe_psum", 32'(pe_psum_in), 32'(exp_psum));
        chk("pe_xw", 32'({pe_x, pe_w}), 32'({fmv, wv}));
      end
      if (live && rst_cyc < 0 && (cyc == 1 || cyc == 27))
        chk("pe_idle_operands", 32'({pe_x, pe_w, pe_psum_in}), 32'd0);
      if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        chk("rst_ctrl", 32'({busy, done, fm_rd_en, w_rd_en}), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_addr", 32'({fm_addr, w_addr}), 32'd0);
        chk("rst_pe", 32'({pe_x, pe_w, pe_psum_in}), 32'd0);
      end
      if (done) begin
        if (done_cyc < 0) begin
          done_cyc = cyc; res1 = result;
        end else if (done2_cyc < 0) begin
          done2_cyc = cyc; res2 = result;
        end
      end
      start = 1'b0;
      rst   = 1'b0;
      if (cyc == restart_cyc) begin
        start = 1'b1; bias = 16'd500; base_addr = 10'd7;
      end
      if (cyc == rst_cyc) rst = 1'b1;
      if (chain && done && cyc == done_cyc) begin
        start = 1'b1; bias = bias2;
      end
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
    if (rst_cyc > 0) begin
      chk("no_done_after_rst", 32'(done_cyc), 32'hFFFF_FFFF);
    end else begin
      chk("done_cycle", 32'(done_cyc), 32'd28);
      chk("result", 32'(res1), 32'(exp));
      chk("busy_first", 32'(busy_first), 32'd1);
      chk("busy_last", 32'(busy_last), 32'd27);
      chk("busy_count", 32'(busy_n), 32'd27);
      chk("read_count", 32'(rd_n), 32'd25);
      chk("result_hold", 32'(result), 32'(chain ? exp2 : exp));
    end
    if (chain) begin
      chk("done2_cycle", 32'(done2_cyc), 32'd56);
      chk("result2", 32'(res2), 32'(exp2));
    end
    $display("[TB] window %0d: fm=%0h w=%0h bias=%0h base=%0d -> done at cycle %0d, result %0h",
             id, fmv, wv, bv, bsv, done_cyc, res1);
  endtask

  initial begin
    // fm, w, bias, base, expected result (hand-computed)
    vecs[0] = '{8'h01, 8'h01, 16'd0,    10'd0,    16'd25};
    vecs[1] = '{8'h02, 8'h03, 16'd10,   10'd0,    16'd160};
    vecs[2] = '{8'hFF, 8'h05, 16'd0,    10'd0,    16'hFF83};
    vecs[3] = '{8'h01, 8'h02, 16'hFFFD, 10'd33,   16'd47};
    vecs[4] = '{8'd100, 8'd50, 16'd100, 10'd0,    16'hE8AC};
    vecs[5] = '{8'h03, 8'hFE, 16'd7,    10'd1000, 16'hFF71};

    rst = 1'b1; start = 1'b0; base_addr = 10'd0; bias = 16'd0;
    for (int i = 0; i < 1024; i++) fm_mem[i] = 8'd0;
    for (int i = 0; i < 32; i++)   w_mem[i]  = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({busy, done, fm_rd_en, w_rd_en}), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_pe", 32'({pe_x, pe_w, pe_psum_in}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ctrl", 32'({busy, done, fm_rd_en, w_rd_en}), 32'd0);

    for (int i = 0; i < 6; i++)
      run_window(i, vecs[i].fm, vecs[i].w, vecs[i].bias, vecs[i].base, vecs[i].exp,
                 -1, -1, 1'b0, 16'd0, 16'd0);

    // Second start mid-window is ignored; base/bias stay latched.
    run_window(6, 8'h02, 8'h03, 16'd10, 10'd0, 16'd160, 10, -1, 1'b0, 16'd0, 16'd0);
    // Reset mid-window aborts with no o_done.
    run_window(7, 8'h02, 8'h03, 16'd10, 10'd0, 16'd160, -1, 12, 1'b0, 16'd0, 16'd0);
    // Start on the o_done cycle: second window (bias -1) done 28 cycles later.
    run_window(8, 8'h02, 8'h03, 16'd10, 10'd0, 16'd160, -1, -1, 1'b1, 16'hFFFF, 16'd149);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
